// File: rtl/rgb2raw_12.sv
// RGB888 stream to RAW12 RGGB Bayer mosaic, packed four pixels per 48-bit word
// with line/frame markers. Camera emulator / loopback source for the de-Bayer path.
module rgb2raw_12 #(
  parameter int unsigned LINE_LENGTH = 640,
  parameter int unsigned FRAME_LINES = 480,
  parameter bit          INV_RB      = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] i_rgb_in,
  input  logic        i_rgb_valid,
  output logic        o_rgb_ready,
  output logic [47:0] o_raw_data,
  output logic        o_raw_valid,
  input  logic        i_raw_ready,
  output logic        o_raw_sol,
  output logic        o_raw_eol,
  output logic        o_raw_sof,
  output logic        o_raw_eof
);

  localparam int unsigned COL_W  = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int unsigned LINE_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

  logic [COL_W-1:0]  r_col;
  logic [LINE_W-1:0] r_line;
  logic [35:0]       r_pack;
  logic [47:0]       r_data;
  logic              r_valid;
  logic              r_sol;
  logic              r_eol;
  logic              r_sof;
  logic              r_eof;

  logic              w_accept;
  logic              w_slot3;
  logic              w_col_last;
  logic              w_line_last;
  logic              w_sol;
  logic [7:0]        w_r8;
  logic [7:0]        w_b8;
  logic [7:0]        w_c8;
  logic [11:0]       w_v12;

  // Input stalls whenever a finished word is still waiting downstream.
  assign o_rgb_ready = ~(r_valid & ~i_raw_ready);
  assign w_accept    = i_rgb_valid & o_rgb_ready;

  assign w_slot3     = (r_col[1:0] == 2'd3);
  assign w_col_last  = (r_col == COL_W'(LINE_LENGTH - 1));
  assign w_line_last = (r_line == LINE_W'(FRAME_LINES - 1));
  assign w_sol       = ((r_col >> 2) == '0);

  assign w_r8 = INV_RB ? ~i_rgb_in[23:16] : i_rgb_in[23:16];
  assign w_b8 = INV_RB ? ~i_rgb_in[7:0]   : i_rgb_in[7:0];

  // RGGB site select from line/column parity.
  always_comb begin
    w_c8 = i_rgb_in[15:8];
    case ({r_line[0], r_col[0]})
      2'b00:   w_c8 = w_r8;
      2'b11:   w_c8 = w_b8;
      default: w_c8 = i_rgb_in[15:8];
    endcase
  end

  // MSB-nibble replication keeps full scale exact: 0x00->0x000, 0xFF->0xFFF.
  assign w_v12 = {w_c8, w_c8[7:4]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col  <= '0;
      r_line <= '0;
    end else if (w_accept) begin
      r_col <= w_col_last ? '0 : r_col + COL_W'(1);
      if (w_col_last) begin
        r_line <= w_line_last ? '0 : r_line + LINE_W'(1);
      end
    end
  end

  // Slots 0-2 shift into the pack register; slot 3 completes and launches the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pack  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sol   <= 1'b0;
      r_eol   <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end else begin
      if (w_accept && w_slot3) begin
        r_data  <= {r_pack, w_v12};
        r_valid <= 1'b1;
        r_sol   <= w_sol;
        r_eol   <= w_col_last;
        r_sof   <= w_sol & (r_line == '0);
        r_eof   <= w_col_last & w_line_last;
      end else begin
        if (w_accept) begin
          r_pack <= {r_pack[23:0], w_v12};
        end
        if (r_valid && i_raw_ready) begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign o_raw_data  = r_data;
  assign o_raw_valid = r_valid;
  assign o_raw_sol   = r_sol;
  assign o_raw_eol   = r_eol;
  assign o_raw_sof   = r_sof;
  assign o_raw_eof   = r_eof;

endmodule

// File: tb/tb_rgb2raw_12.sv
// Bench for rgb2raw_12: directed vectors plus a pixel-index scoreboard model
// checked on every consumed word; a second instance covers R/B inversion.
module tb_rgb2raw_12;

  localparam int unsigned L = 8;
  localparam int unsigned F = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] rgb;
  logic        rgb_valid;
  logic        rgb_ready;
  logic [47:0] raw_data;
  logic        raw_valid;
  logic        raw_ready;
  logic        sol, eol, sof, eof;

  logic [23:0] rgb1;
  logic        rgb1_valid;
  logic        rgb1_ready;
  logic [47:0] raw1_data;
  logic        raw1_valid;
  logic        raw1_ready;
  logic        sol1, eol1, sof1, eof1;

  int          checks;
  int          errors;
  int          pix;
  bit          hold;
  logic [51:0] held;
  logic [11:0] part[$];
  logic [51:0] exp_q[$];
  logic [51:0] got_q[$];
  logic [47:0] got1_q[$];

  always #5 clk = ~clk;

  rgb2raw_12 #(.LINE_LENGTH(L), .FRAME_LINES(F), .INV_RB(1'b0)) dut (
    .clk(clk), .rst(rst),
    .i_rgb_in(rgb), .i_rgb_valid(rgb_valid), .o_rgb_ready(rgb_ready),
    .o_raw_data(raw_data), .o_raw_valid(raw_valid), .i_raw_ready(raw_ready),
    .o_raw_sol(sol), .o_raw_eol(eol), .o_raw_sof(sof), .o_raw_eof(eof)
  );

  rgb2raw_12 #(.LINE_LENGTH(L), .FRAME_LINES(F), .INV_RB(1'b1)) dut_inv (
    .clk(clk), .rst(rst),
    .i_rgb_in(rgb1), .i_rgb_valid(rgb1_valid), .o_rgb_ready(rgb1_ready),
    .o_raw_data(raw1_data), .o_raw_valid(raw1_valid), .i_raw_ready(raw1_ready),
    .o_raw_sol(sol1), .o_raw_eol(eol1), .o_raw_sof(sof1), .o_raw_eof(eof1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bayer sample of one pixel at (line, col), from the colour-site rules.
  function automatic logic [11:0] model_px(input logic [23:0] px, input int line,
                                           input int col, input bit inv);
    int r, g, b, c;
    r = int'(px[23:16]);
    g = int'(px[15:8]);
    b = int'(px[7:0]);
    if (inv) begin
      r = 255 - r;
      b = 255 - b;
    end
    if (line % 2 == 0) c = (col % 2 == 0) ? r : g;
    else               c = (col % 2 == 0) ? g : b;
    return 12'(c * 16 + c / 16);
  endfunction

  task automatic mon0();
    logic [51:0] obs;
    logic [3:0]  fl;
    int line, col;
    obs = {sol, eol, sof, eof, raw_data};
    if (rst) begin
      pix = 0;
      part.delete();
      exp_q.delete();
      hold = 1'b0;
    end else begin
      chk("rgb_ready", 64'(rgb_ready), 64'(!(raw_valid && !raw_ready)));
      if (hold) chk("hold_stable", 64'({raw_valid, obs}), 64'({1'b1, held}));
      if (raw_valid && raw_ready) begin
        got_q.push_back(obs);
        chk("word_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) chk("word", 64'(obs), 64'(exp_q.pop_front()));
      end
      if (rgb_valid && rgb_ready) begin
        line = (pix / int'(L)) % int'(F);
        col  = pix % int'(L);
        part.push_back(model_px(rgb, line, col, 1'b0));
        if (part.size() == 4) begin
          fl[3] = (col / 4 == 0);
          fl[2] = (col == int'(L) - 1);
          fl[1] = fl[3] && (line == 0);
          fl[0] = fl[2] && (line == int'(F) - 1);
          exp_q.push_back({fl, part[0], part[1], part[2], part[3]});
          part.delete();
        end
        pix = (pix + 1) % int'(L * F);
      end
      hold = raw_valid && !raw_ready;
      held = obs;
    end
  endtask

  task automatic mon1();
    if (!rst) begin
      chk("inv_rgb_ready", 64'(rgb1_ready), 64'(1));
      if (raw1_valid) got1_q.push_back(raw1_data);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rgb_valid = 1'b0;
    rgb1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out", 64'({raw_valid, sol, eol, sof, eof, raw_data}), 64'(0));
    chk("reset_rgb_ready", 64'(rgb_ready), 64'(1));
  endtask

  task automatic send_px(input logic [23:0] px);
    bit acc;
    int n;
    rgb = px;
    rgb_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = rgb_ready;
      @(posedge clk);
      #1 n++;
    end
    chk("input_accept", 64'(acc), 64'(1));
  endtask

  task automatic idle(input int n);
    rgb_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [51:0] w;
    bit done;
    int n;
    rst = 1'b1; rgb = '0; rgb_valid = 1'b0; raw_ready = 1'b1;
    rgb1 = '0; rgb1_valid = 1'b0; raw1_ready = 1'b1;
    checks = 0; errors = 0; pix = 0; hold = 1'b0; held = '0; done = 1'b0;
    fork
      forever begin
        @(negedge clk);
        mon0();
        mon1();
      end
    join_none
    do_reset();

    // Inverted instance: lines 0,1 of 0x00FF00 then line 2 of 0xFFFFFF.
    for (int i = 0; i < int'(3 * L); i++) begin
      rgb1 = (i < int'(2 * L)) ? 24'h00FF00 : 24'hFFFFFF;
      rgb1_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    rgb1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("inv_count", 64'(got1_q.size()), 64'(6));
    chk("inv_line0", 64'(got1_q[0]), 64'(48'hFFFFFFFFFFFF));
    chk("inv_line1", 64'(got1_q[2]), 64'(48'hFFFFFFFFFFFF));
    chk("inv_white", 64'(got1_q[4]), 64'(48'h000FFF000FFF));

    // Line 0 solid red, line 1 green+mid blue.
    got_q.delete();
    for (int i = 0; i < int'(L); i++) send_px(24'hFF0000);
    for (int i = 0; i < int'(L); i++) send_px(24'h00FF80);
    idle(3);
    chk("l0_count", 64'(got_q.size()), 64'(4));
    chk("l0_w0", 64'(got_q[0]), 64'(52'hA_FFF000FFF000));
    chk("l0_w1", 64'(got_q[1]), 64'(52'h4_FFF000FFF000));
    chk("l1_w0", 64'(got_q[2]), 64'(52'h8_FFF808FFF808));
    chk("l1_w1", 64'(got_q[3]), 64'(52'h4_FFF808FFF808));

    // Line 2 under a 10-cycle downstream stall, line 3 free-running.
    fork
      begin
        for (int i = 0; i < int'(L); i++) send_px(24'($urandom));
      end
      begin
        raw_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("stall_rgb_ready", 64'(rgb_ready), 64'(0));
        chk("stall_pending", 64'(raw_valid), 64'(1));
        raw_ready = 1'b1;
      end
    join
    for (int i = 0; i < int'(L); i++) send_px(24'($urandom));
    for (int i = 0; i < 4; i++) send_px(24'($urandom));
    idle(3);
    chk("frame_count", 64'(got_q.size()), 64'(9));
    w = got_q[6];
    chk("l3_w0_flags", 64'(w[51:48]), 64'(4'h8));
    w = got_q[7];
    chk("eof_flags", 64'(w[51:48]), 64'(4'h5));
    w = got_q[8];
    chk("next_sof_flags", 64'(w[51:48]), 64'(4'hA));

    // A word left pending at reset is dropped.
    raw_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_px(24'hABCDEF);
    idle(2);
    chk("pending_before_reset", 64'(raw_valid), 64'(1));
    got_q.delete();
    do_reset();
    raw_ready = 1'b1;
    idle(3);
    chk("pending_dropped", 64'(got_q.size()), 64'(0));

    // Reset two pixels into a word; the partial pack is discarded.
    send_px(24'h777777);
    send_px(24'h777777);
    do_reset();
    got_q.delete();
    for (int i = 0; i < 4; i++) send_px(24'h123456);
    idle(3);
    chk("restart_count", 64'(got_q.size()), 64'(1));
    chk("restart_word", 64'(got_q[0]), 64'(52'hA_121343121343));

    // Two frames with random input gaps and random downstream backpressure.
    do_reset();
    fork
      begin
        for (int i = 0; i < int'(2 * L * F); i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send_px(24'($urandom));
        end
        rgb_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 raw_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    raw_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    idle(2);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    chk("no_partial", 64'(part.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
